// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Sits between the CPU memory stage and the word-addressed data memory.
// Each line holds four 32-bit words. A miss turns into an optional
// write-back of the dirty victim line, followed by a line refill.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a CPU request; latches it when one arrives
// COMPARE    | tag lookup; a hit completes the request, a miss leaves
// WB_REQ     | write-back of the dirty victim line, waiting for mem ready
// ALLOC_REQ  | refill request for the missing line, waiting for mem ready
// ALLOC_WAIT | waiting for the refill data, then back to COMPARE
module data_cache #(
  parameter int NUM_SETS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_req_valid,
  input  logic         cpu_req_we,
  input  logic [31:0]  cpu_req_addr,
  input  logic [31:0]  cpu_req_wdata,
  output logic         cpu_ready,
  output logic         cpu_resp_valid,
  output logic [31:0]  cpu_resp_rdata,
  output logic         cpu_hit,
  output logic         mem_req_valid,
  output logic         mem_req_we,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_wdata,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_rdata,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 32 - 4 - IW;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB_REQ,
    ALLOC_REQ,
    ALLOC_WAIT
  } state_t;

  state_t state_q, state_d;

  // Latched request; the byte-offset bits never matter for word accesses.
  logic        req_we_q;
  logic [31:2] req_addr_q;
  logic [31:0] req_wdata_q;
  logic        missed_q;

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [127:0]        line_q [NUM_SETS];

  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [1:0]    word_sel;
  logic [6:0]    word_lsb;
  logic          lookup_hit;
  logic [127:0]  cur_line;
  logic [TW-1:0] cur_tag;

  assign req_idx    = req_addr_q[4+IW-1:4];
  assign req_tag    = req_addr_q[31:4+IW];
  assign word_sel   = req_addr_q[3:2];
  assign word_lsb   = {word_sel, 5'b0};
  assign cur_line   = line_q[req_idx];
  assign cur_tag    = tag_q[req_idx];
  assign lookup_hit = valid_q[req_idx] && (cur_tag == req_tag);

  logic accept;
  logic complete;
  logic record_miss;
  logic store_we;
  logic refill_we;

  // Next-state and output decode; outputs depend only on state and registers.
  always_comb begin
    state_d        = state_q;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = 32'h0;
    cpu_hit        = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = 32'h0;
    mem_req_wdata  = 128'h0;
    accept         = 1'b0;
    complete       = 1'b0;
    record_miss    = 1'b0;
    store_we       = 1'b0;
    refill_we      = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) begin
          accept  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (lookup_hit) begin
          cpu_resp_valid = 1'b1;
          cpu_hit        = !missed_q;
          complete       = 1'b1;
          if (req_we_q) begin
            store_we = 1'b1;
          end else begin
            cpu_resp_rdata = cur_line[word_lsb +: 32];
          end
          state_d = IDLE;
        end else begin
          record_miss = !missed_q;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WB_REQ;
          end else begin
            state_d = ALLOC_REQ;
          end
        end
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {cur_tag, req_idx, 4'b0};
        mem_req_wdata = cur_line;
        if (mem_req_ready) begin
          state_d = ALLOC_REQ;
        end
      end
      ALLOC_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_idx, 4'b0};
        if (mem_req_ready) begin
          state_d = ALLOC_WAIT;
        end
      end
      ALLOC_WAIT: begin
        if (mem_resp_valid) begin
          refill_we = 1'b1;
          state_d   = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch and the per-request "already missed" flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'h0;
      missed_q    <= 1'b0;
    end else if (accept) begin
      req_we_q    <= cpu_req_we;
      req_addr_q  <= cpu_req_addr[31:2];
      req_wdata_q <= cpu_req_wdata;
      missed_q    <= 1'b0;
    end else if (record_miss) begin
      missed_q <= 1'b1;
    end
  end

  // Valid and dirty bits; reset discards any dirty data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_we) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (store_we) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are never cleared; valid_q guards their contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (refill_we) begin
        tag_q[req_idx]  <= req_tag;
        line_q[req_idx] <= mem_resp_rdata;
      end else if (store_we) begin
        line_q[req_idx][word_lsb +: 32] <= req_wdata_q;
      end
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      if (complete && !missed_q) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (record_miss) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
